// File: rtl/block_feed_pkg.sv
// Shared types and constants for the block feed controller.
// Holds the FSM state encoding, block geometry and padding constants,
// plus a helper that selects one byte of the 64-bit length field.
package block_feed_pkg;

  localparam int          BLOCK_BYTES = 64;
  localparam int          LEN_BYTES   = 8;
  localparam int          LEN_OFFSET  = BLOCK_BYTES - LEN_BYTES;
  localparam logic [7:0]  PAD_BYTE    = 8'h80;
  // Each accepted byte adds eight bits to the message length.
  localparam logic [63:0] LEN_STEP    = 64'd8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PAD80,
    ST_PADZ,
    ST_LEN,
    ST_WAIT_ACK
  } state_t;

  // Byte idx of the length field, idx 0 being the most significant byte.
  function automatic logic [7:0] len_byte(input logic [63:0] len, input logic [2:0] idx);
    return 8'(len >> (8 * (LEN_BYTES - 1 - int'(idx))));
  endfunction

endpackage

// File: rtl/msg_len_counter.sv
// Purpose: 64-bit message bit-length counter with clear, +8 step and latch.
// Latency: count and latched value update on the clock after clr/inc/latch.
// Backpressure: none; the caller qualifies inc with its own handshake.
// Ports: clk, rst (async, active-high); clr restarts from zero (an inc in
// the same cycle still counts); inc adds 8; latch captures the updated count
// into len_lat, which is what the length field is built from.
module msg_len_counter
  import block_feed_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        inc,
  input  logic        latch,
  output logic [63:0] len_lat
);

  logic [63:0] cnt;
  logic [63:0] cnt_nxt;

  // Wraps modulo 2^64 by plain overflow.
  always_comb begin
    cnt_nxt = (clr ? 64'd0 : cnt) + (inc ? LEN_STEP : 64'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= 64'd0;
      len_lat <= 64'd0;
    end else begin
      cnt <= cnt_nxt;
      // Latching the post-increment value includes the final byte itself.
      if (latch) len_lat <= cnt_nxt;
    end
  end

endmodule

// File: rtl/block_feed_ctrl.sv
// Purpose: feeds message bytes, 0x80 pad, zero pad and length into a block shift register.
// Latency: an accepted or generated byte appears on shift_en/shift_data one cycle later.
// Backpressure: byte_ready drops while a full block waits for block_ack; pads need no handshake.
// Ports: byte_valid/byte_data/byte_last/byte_ready upstream byte stream;
// shift_en/shift_data one-byte strobe to the external shift register;
// block_valid/block_last/block_ack downstream block handshake; busy = message active.
module block_feed_ctrl #(
  parameter int BLOCK_BYTES = block_feed_pkg::BLOCK_BYTES,
  parameter int LEN_BYTES   = block_feed_pkg::LEN_BYTES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  input  logic       byte_last,
  output logic       byte_ready,
  output logic       shift_en,
  output logic [7:0] shift_data,
  output logic       block_valid,
  output logic       block_last,
  input  logic       block_ack,
  output logic       busy
);
  import block_feed_pkg::*;

  localparam int         LEN_START   = BLOCK_BYTES - LEN_BYTES;
  localparam logic [5:0] POS_LAST    = 6'(BLOCK_BYTES - 1);
  localparam logic [5:0] POS_PRE_LEN = 6'(LEN_START - 1);

  state_t      state, state_nxt, state_tgt;
  state_t      resume, resume_nxt;
  logic [5:0]  pos;
  logic [5:0]  issue_pos;
  logic        accept;
  logic        issue;
  logic [7:0]  issue_dat;
  logic [63:0] len_lat;

  // pos counts shifts already on the output; a byte still in the shift_en
  // register occupies the next slot, so the byte being issued now lands here.
  assign issue_pos  = pos + {5'd0, shift_en};
  assign byte_ready = !rst && !block_valid && (state == ST_IDLE || state == ST_LOAD);
  assign accept     = byte_valid && byte_ready;
  assign busy       = (state != ST_IDLE);

  msg_len_counter u_len (
    .clk     (clk),
    .rst     (rst),
    .clr     (state == ST_IDLE),
    .inc     (accept),
    .latch   (accept && byte_last),
    .len_lat (len_lat)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      resume <= ST_IDLE;
    end else begin
      state  <= state_nxt;
      resume <= resume_nxt;
    end
  end

  // Next state: state_tgt is where the FSM goes after this byte; when the
  // byte fills the last slot of a block it becomes the resume point instead.
  always_comb begin
    state_nxt  = state;
    resume_nxt = resume;
    state_tgt  = state;
    case (state)
      ST_IDLE, ST_LOAD: if (accept) state_tgt = byte_last ? ST_PAD80 : ST_LOAD;
      ST_PAD80, ST_PADZ: state_tgt = (issue_pos == POS_PRE_LEN) ? ST_LEN : ST_PADZ;
      ST_LEN:           state_tgt = (issue_pos == POS_LAST) ? ST_IDLE : ST_LEN;
      ST_WAIT_ACK:      if (block_valid && block_ack) state_tgt = resume;
      default:          state_tgt = ST_IDLE;
    endcase
    if (issue && issue_pos == POS_LAST) begin
      state_nxt  = ST_WAIT_ACK;
      resume_nxt = state_tgt;
    end else begin
      state_nxt  = state_tgt;
    end
  end

  // Output decode: which byte, if any, is issued this cycle.
  always_comb begin
    issue     = 1'b0;
    issue_dat = 8'h00;
    case (state)
      ST_IDLE, ST_LOAD: begin
        issue     = accept;
        issue_dat = byte_data;
      end
      ST_PAD80: begin
        issue     = 1'b1;
        issue_dat = PAD_BYTE;
      end
      ST_PADZ: issue = 1'b1;
      ST_LEN: begin
        issue     = 1'b1;
        issue_dat = len_byte(len_lat, 3'(issue_pos - 6'(LEN_START)));
      end
      default: issue = 1'b0;
    endcase
  end

  // Registered shift strobe, position counter and block handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_en    <= 1'b0;
      shift_data  <= 8'h00;
      pos         <= 6'd0;
      block_valid <= 1'b0;
      block_last  <= 1'b0;
    end else begin
      shift_en <= issue;
      if (issue) shift_data <= issue_dat;
      if (shift_en) pos <= pos + 6'd1;
      if (shift_en && pos == POS_LAST) begin
        block_valid <= 1'b1;
        // Only the length block resumes into IDLE.
        block_last  <= (resume == ST_IDLE);
      end else if (state == ST_WAIT_ACK && block_valid && block_ack) begin
        block_valid <= 1'b0;
        block_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_block_feed_ctrl.sv
// Purpose: self-checking bench for block_feed_ctrl.
// Latency: n/a.
// Backpressure: n/a.
module tb_block_feed_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       byte_valid, byte_last, byte_ready;
  logic [7:0] byte_data;
  logic       shift_en, block_valid, block_last, block_ack, busy;
  logic [7:0] shift_data;

  int checks = 0;
  int errors = 0;

  logic [7:0] msg[$];
  logic [7:0] shifts[$];
  logic       blk_last[$];
  int         blk_pos[$];
  int         viol = 0;

  bit ack_hold  = 1'b0;
  bit ack_rand  = 1'b1;
  bit ack_force = 1'b0;
  bit mon_en    = 1'b1;

  typedef struct {
    int          n;
    int          vpct;
    bit          abc;
    int          exp_blocks;
    logic [63:0] exp_len;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  block_feed_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .byte_last   (byte_last),
    .byte_ready  (byte_ready),
    .shift_en    (shift_en),
    .shift_data  (shift_data),
    .block_valid (block_valid),
    .block_last  (block_last),
    .block_ack   (block_ack),
    .busy        (busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Downstream acknowledger.
  initial begin
    block_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      block_ack = ack_force ||
                  (!ack_hold && block_valid && (!ack_rand || $urandom_range(3) != 0));
    end
  end

  // Monitor: collect shifted bytes and block boundaries.
  always @(negedge clk) begin
    if (mon_en) begin
      if (shift_en) shifts.push_back(shift_data);
      if (shift_en && block_valid) viol++;
      if (block_valid && block_ack) begin
        blk_last.push_back(block_last);
        blk_pos.push_back(shifts.size());
      end
    end
  end

  task automatic clear_mon();
    shifts.delete();
    blk_last.delete();
    blk_pos.delete();
    viol = 0;
  endtask

  task automatic make_msg(input int n, input bit abc);
    msg.delete();
    for (int i = 0; i < n; i++) msg.push_back(abc ? 8'(8'h61 + i) : 8'($urandom));
  endtask

  // Drives msg upstream; stop_after >= 0 stops after that many accepts.
  task automatic send_msg(input int vpct, input int stop_after);
    int idx = 0;
    int guard = 0;
    bit acc;
    while (idx < msg.size()) begin
      if (stop_after >= 0 && idx >= stop_after) break;
      byte_data  = msg[idx];
      byte_last  = (idx == msg.size() - 1);
      byte_valid = ($urandom_range(99) < vpct);
      #1;
      acc = byte_valid && byte_ready;
      @(posedge clk);
      #1;
      if (acc) idx++;
      guard++;
      if (guard > 5000) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: accepted %0d of %0d bytes", idx, msg.size());
        break;
      end
    end
    byte_valid = 1'b0;
    byte_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int g = 0;
    @(negedge clk);
    while ((busy || block_valid) && g < 4000) begin
      @(negedge clk);
      g++;
    end
    chk("idle_reached_busy", {63'd0, busy}, 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Reference: message, 0x80, zeros up to offset 56 mod 64, 64-bit bit length MSB first.
  task automatic check_msg(input string tag, input int exp_blocks, input logic [63:0] exp_len);
    logic [7:0]  e[$];
    logic [63:0] bl;
    logic [63:0] lf;
    int mism = 0;
    int bad_last = 0;
    int bad_pos = 0;
    e = msg;
    e.push_back(8'h80);
    while (e.size() % 64 != 56) e.push_back(8'h00);
    bl = 64'(msg.size()) * 64'd8;
    for (int k = 7; k >= 0; k--) e.push_back(bl[8*k +: 8]);
    chk({tag, "/shift_count"}, 64'(shifts.size()), 64'(e.size()));
    for (int i = 0; i < e.size() && i < shifts.size(); i++)
      if (shifts[i] !== e[i]) begin
        if (mism == 0) $display("  first difference at byte %0d: got %0h, expected %0h", i, shifts[i], e[i]);
        mism++;
      end
    chk({tag, "/stream_diff_bytes"}, 64'(mism), 64'd0);
    chk({tag, "/block_count"}, 64'(blk_last.size()), 64'(exp_blocks));
    for (int k = 0; k < blk_last.size(); k++) begin
      if (blk_last[k] !== (k == blk_last.size() - 1)) bad_last++;
      if (blk_pos[k] != 64 * (k + 1)) bad_pos++;
    end
    chk({tag, "/block_last_flags_bad"}, 64'(bad_last), 64'd0);
    chk({tag, "/block_boundary_bad"}, 64'(bad_pos), 64'd0);
    lf = 64'd0;
    if (shifts.size() >= 8)
      for (int k = 0; k < 8; k++) lf = {lf[55:0], shifts[shifts.size() - 8 + k]};
    chk({tag, "/len_field"}, lf, exp_len);
    chk({tag, "/shift_while_block_valid"}, 64'(viol), 64'd0);
    clear_mon();
  endtask

  initial begin
    int bad;
    int g;
    vecs[0] = '{n: 3,   vpct: 100, abc: 1'b1, exp_blocks: 1, exp_len: 64'h18};
    vecs[1] = '{n: 56,  vpct: 100, abc: 1'b0, exp_blocks: 2, exp_len: 64'h1C0};
    vecs[2] = '{n: 64,  vpct: 100, abc: 1'b0, exp_blocks: 2, exp_len: 64'h200};
    vecs[3] = '{n: 55,  vpct: 50,  abc: 1'b0, exp_blocks: 1, exp_len: 64'h1B8};
    vecs[4] = '{n: 1,   vpct: 100, abc: 1'b0, exp_blocks: 1, exp_len: 64'h8};
    vecs[5] = '{n: 63,  vpct: 70,  abc: 1'b0, exp_blocks: 2, exp_len: 64'h1F8};
    vecs[6] = '{n: 119, vpct: 60,  abc: 1'b0, exp_blocks: 2, exp_len: 64'h3B8};
    vecs[7] = '{n: 128, vpct: 80,  abc: 1'b0, exp_blocks: 3, exp_len: 64'h400};

    rst = 1'b1;
    byte_valid = 1'b0;
    byte_last = 1'b0;
    byte_data = 8'h00;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst/shift_en", {63'd0, shift_en}, 64'd0);
    chk("rst/shift_data", {56'd0, shift_data}, 64'd0);
    chk("rst/block_valid", {63'd0, block_valid}, 64'd0);
    chk("rst/block_last", {63'd0, block_last}, 64'd0);
    chk("rst/busy", {63'd0, busy}, 64'd0);
    chk("rst/byte_ready", {63'd0, byte_ready}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("post_rst/byte_ready", {63'd0, byte_ready}, 64'd1);
    @(posedge clk);
    #1;
    clear_mon();

    // Stray block_ack while idle must be ignored.
    ack_force = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    ack_force = 1'b0;
    #1;
    chk("stray_ack/block_valid", {63'd0, block_valid}, 64'd0);
    chk("stray_ack/busy", {63'd0, busy}, 64'd0);
    chk("stray_ack/byte_ready", {63'd0, byte_ready}, 64'd1);

    // Table-driven messages
    for (int v = 0; v < 8; v++) begin
      make_msg(vecs[v].n, vecs[v].abc);
      send_msg(vecs[v].vpct, -1);
      wait_idle();
      if (vecs[v].abc && shifts.size() >= 64) begin
        chk("abc/byte3_pad", {56'd0, shifts[3]}, 64'h80);
        chk("abc/byte4_zero", {56'd0, shifts[4]}, 64'h00);
        chk("abc/byte63_len", {56'd0, shifts[63]}, 64'h18);
      end
      check_msg($sformatf("vec%0d_len%0d", v, vecs[v].n), vecs[v].exp_blocks, vecs[v].exp_len);
    end

    // Withheld acknowledge for 10 cycles on the first block of a 64-byte message
    make_msg(64, 1'b0);
    ack_hold = 1'b1;
    ack_rand = 1'b0;
    fork
      send_msg(100, -1);
      begin
        g = 0;
        bad = 0;
        while (!block_valid && g < 2000) begin
          @(negedge clk);
          g++;
        end
        chk("hold/block_valid_seen", {63'd0, block_valid}, 64'd1);
        for (int c = 0; c < 10; c++) begin
          if (block_valid !== 1'b1 || byte_ready !== 1'b0 || shift_en !== 1'b0 || busy !== 1'b1) bad++;
          if (c == 9) ack_hold = 1'b0;
          @(negedge clk);
        end
        chk("hold/bad_cycles", 64'(bad), 64'd0);
        chk("hold/ack_cycle_valid", {63'd0, block_valid}, 64'd1);
        chk("hold/ack_cycle_ack", {63'd0, block_ack}, 64'd1);
        @(negedge clk);
        chk("hold/valid_drops", {63'd0, block_valid}, 64'd0);
      end
    join
    ack_hold = 1'b0;
    wait_idle();
    check_msg("hold_msg", 2, 64'h200);
    ack_rand = 1'b1;

    // Reset after 20 accepted bytes, then a fresh 3-byte message
    make_msg(40, 1'b0);
    send_msg(100, 20);
    rst = 1'b1;
    #1;
    chk("midrst/shift_en", {63'd0, shift_en}, 64'd0);
    chk("midrst/shift_data", {56'd0, shift_data}, 64'd0);
    chk("midrst/block_valid", {63'd0, block_valid}, 64'd0);
    chk("midrst/block_last", {63'd0, block_last}, 64'd0);
    chk("midrst/busy", {63'd0, busy}, 64'd0);
    chk("midrst/byte_ready", {63'd0, byte_ready}, 64'd0);
    chk("midrst/no_block", 64'(blk_last.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("midrst/byte_ready_after", {63'd0, byte_ready}, 64'd1);
    @(posedge clk);
    #1;
    clear_mon();
    make_msg(3, 1'b0);
    send_msg(100, -1);
    wait_idle();
    check_msg("after_rst_3B", 1, 64'h18);

    // Random messages against the reference
    for (int r = 0; r < 5; r++) begin
      int n;
      n = $urandom_range(150, 1);
      make_msg(n, 1'b0);
      send_msg($urandom_range(100, 30), -1);
      wait_idle();
      check_msg($sformatf("rand%0d_len%0d", r, n), (((n + 9 + 63) / 64)), 64'(n) * 64'd8);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks so far", checks);
    $fatal(1, "watchdog");
  end

endmodule
